output_checker: RTL

OUTPUT_CHECKER -- requirements
Module: output_checker

---
 rtl/output_checker.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/output_checker.sv
// Compares a filter output stream against a preloaded table of expected samples
// within +/-TOL, counting mismatches and reporting pass/fail at the end of a run.
module output_checker #(
   parameter int Nb    = 10,
   parameter int DEPTH = 64,
   parameter int AW    = 6,
   parameter int TOL   = 1
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          LD_EN,
   input  logic [Nb-1:0] LD_DATA,
   input  logic          START,
   input  logic [Nb-1:0] DIN,
   input  logic          VIN,
   output logic          MISMATCH,
   output logic [AW:0]   ERR_CNT,
   output logic [AW:0]   SAMPLE_CNT,
   output logic [AW:0]   LOADED,
   output logic          OVF,
   output logic          DONE,
   output logic          PASS
);

   typedef enum logic [1:0] {IDLE, LOAD, CHECK, FINISH} state_t;

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE  = (AW+1)'(1);

   // Operands are sign-extended by one bit so the difference can never wrap.
   function automatic logic within_tol(input logic [Nb-1:0] a, input logic [Nb-1:0] b);
      logic signed [Nb:0] diff;
      diff = $signed({a[Nb-1], a}) - $signed({b[Nb-1], b});
      return (int'(diff) >= -TOL) && (int'(diff) <= TOL);
   endfunction

   function automatic logic [AW:0] sat_inc(input logic [AW:0] c);
      return (c == '1) ? c : c + ONE;
   endfunction

   state_t        state_q, state_d;
   logic [AW:0]   loaded_q, loaded_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   err_cnt_q, err_cnt_d;
   logic [AW:0]   sample_cnt_q, sample_cnt_d;
   logic          ovf_q, ovf_d;
   logic          mismatch_q, mismatch_d;
   logic          done_q, done_d;
   logic          pass_q, pass_d;

   logic [Nb-1:0] mem [DEPTH];
   logic          mem_we;
   logic [AW-1:0] mem_wa;
   logic [Nb-1:0] exp_sample;

   assign exp_sample = mem[rd_ptr_q];

   always_ff @(posedge CLK) begin
      if (mem_we) mem[mem_wa] <= LD_DATA;
   end

   always_comb begin
      state_d      = state_q;
      loaded_d     = loaded_q;
      rd_ptr_d     = rd_ptr_q;
      err_cnt_d    = err_cnt_q;
      sample_cnt_d = sample_cnt_q;
      ovf_d        = ovf_q;
      mismatch_d   = 1'b0;
      done_d       = done_q;
      pass_d       = pass_q;
      mem_we       = 1'b0;
      mem_wa       = '0;

      if (START) begin
         // A fresh run; an empty table finishes immediately as a trivial pass.
         rd_ptr_d     = '0;
         err_cnt_d    = '0;
         sample_cnt_d = '0;
         if (loaded_q == '0) begin
            state_d = FINISH;
            done_d  = 1'b1;
            pass_d  = 1'b1;
         end else begin
            state_d = CHECK;
            done_d  = 1'b0;
            pass_d  = 1'b0;
         end
      end else begin
         case (state_q)
            IDLE, FINISH: begin
               if (LD_EN) begin
                  mem_we   = 1'b1;
                  mem_wa   = '0;
                  loaded_d = ONE;
                  ovf_d    = 1'b0;
                  done_d   = 1'b0;
                  pass_d   = 1'b0;
                  state_d  = LOAD;
               end
            end
            LOAD: begin
               if (LD_EN) begin
                  if (loaded_q < FULL) begin
                     mem_we   = 1'b1;
                     mem_wa   = loaded_q[AW-1:0];
                     loaded_d = loaded_q + ONE;
                  end else begin
                     ovf_d = 1'b1;
                  end
               end
            end
            CHECK: begin
               if (VIN) begin
                  rd_ptr_d     = rd_ptr_q + 1'b1;
                  sample_cnt_d = sample_cnt_q + ONE;
                  if (!within_tol(DIN, exp_sample)) begin
                     mismatch_d = 1'b1;
                     err_cnt_d  = sat_inc(err_cnt_q);
                  end
                  if (sample_cnt_q + ONE == loaded_q) begin
                     state_d = FINISH;
                     done_d  = 1'b1;
                     pass_d  = (err_cnt_d == '0);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= IDLE;
         loaded_q     <= '0;
         rd_ptr_q     <= '0;
         err_cnt_q    <= '0;
         sample_cnt_q <= '0;
         ovf_q        <= 1'b0;
         mismatch_q   <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         loaded_q     <= loaded_d;
         rd_ptr_q     <= rd_ptr_d;
         err_cnt_q    <= err_cnt_d;
         sample_cnt_q <= sample_cnt_d;
         ovf_q        <= ovf_d;
         mismatch_q   <= mismatch_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
      end
   end

   assign MISMATCH   = mismatch_q;
   assign ERR_CNT    = err_cnt_q;
   assign SAMPLE_CNT = sample_cnt_q;
   assign LOADED     = loaded_q;
   assign OVF        = ovf_q;
   assign DONE       = done_q;
   assign PASS       = pass_q;

endmodule
